// File: rtl/operand_swap_pipe.sv
// operand_swap_pipe
//   Two-stage operand-swap stage that sits ahead of the alignment shifter in
//   the fused multiply-add datapath. Each beat presents two operands. The
//   stage forwards them either straight or exchanged. In manual mode the
//   external select makes the choice. In auto mode an unsigned magnitude
//   compare makes it, and the larger operand goes to out1. A saturating
//   counter records how many swapped beats have entered the output stage.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready is combinational from out_ready)
//   op1, op2          input operands, WIDTH bits
//   sel, mode         manual swap select; 0 = manual, 1 = auto compare
//   out_valid/out_ready output handshake
//   out1, out2        result operands, WIDTH bits
//   swapped           1 = out1/out2 carry op2/op1 for the current beat
//   cnt_clr           clear the swap counter (wins over increment)
//   swap_cnt          saturating count of swapped beats entering S2
module operand_swap_pipe #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sel,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             swapped,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] swap_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage S1 holds the raw operands and the swap decision.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_op1;
  logic [WIDTH-1:0] s1_op2;
  logic             s1_swap;

  logic s2_adv_c;
  logic in_fire_c;
  logic s2_load_c;
  logic swap_dec_c;

  // Handshake and swap-decision logic.
  // out_valid is the S2 valid flag itself.
  always_comb begin
    s2_adv_c   = 1'b0;
    in_ready   = 1'b0;
    in_fire_c  = 1'b0;
    s2_load_c  = 1'b0;
    swap_dec_c = 1'b0;

    s2_adv_c   = !out_valid || out_ready;
    in_ready   = !s1_valid || s2_adv_c;
    in_fire_c  = in_valid && in_ready;
    s2_load_c  = s1_valid && s2_adv_c;
    // On a tie the operands stay straight.
    swap_dec_c = mode ? (op2 > op1) : sel;
  end

  // S1 register: valid follows in_valid whenever S1 can move.
  // Operands load only on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_swap  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire_c) begin
        s1_op1  <= op1;
        s1_op2  <= op2;
        s1_swap <= swap_dec_c;
      end
    end
  end

  // S2 register: the data outputs change only when a beat loads.
  // They hold while the stage is stalled or empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out1      <= '0;
      out2      <= '0;
      swapped   <= 1'b0;
    end else begin
      if (s2_adv_c) begin
        out_valid <= s1_valid;
      end
      if (s2_load_c) begin
        out1    <= s1_swap ? s1_op2 : s1_op1;
        out2    <= s1_swap ? s1_op1 : s1_op2;
        swapped <= s1_swap;
      end
    end
  end

  // Swap counter: cnt_clr wins over increment, and the count saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_cnt <= '0;
    end else if (cnt_clr) begin
      swap_cnt <= '0;
    end else if (s2_load_c && s1_swap && (swap_cnt != CNT_MAX)) begin
      swap_cnt <= swap_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_swap_pipe.sv
// Self-checking bench for operand_swap_pipe. Two instances share the same
// stimulus. One uses the default 16-bit counter and the other a 2-bit counter,
// so that saturation shows up. A transaction-level model checks both: a
// two-entry FIFO whose head becomes visible one edge after entry, plus
// plain-integer saturating counters.
module tb_operand_swap_pipe;

  localparam int unsigned WIDTH = 48;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             sel;
  logic             mode;
  logic             out_ready;
  logic             cnt_clr;

  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             swapped;
  logic [15:0]      swap_cnt;

  logic             in_ready_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] out1_s;
  logic [WIDTH-1:0] out2_s;
  logic             swapped_s;
  logic [1:0]       swap_cnt_s;

  operand_swap_pipe #(.WIDTH(WIDTH), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .sel(sel), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out2(out2), .swapped(swapped),
    .cnt_clr(cnt_clr), .swap_cnt(swap_cnt)
  );

  operand_swap_pipe #(.WIDTH(WIDTH), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .op1(op1), .op2(op2), .sel(sel), .mode(mode),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out1(out1_s), .out2(out2_s), .swapped(swapped_s),
    .cnt_clr(cnt_clr), .swap_cnt(swap_cnt_s)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model.
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sw;
    bit               at_out;
  } beat_t;

  beat_t            q[$];
  logic [WIDTH-1:0] m_o1;
  logic [WIDTH-1:0] m_o2;
  logic             m_sw;
  int               m_cnt16;
  int               m_cnt2;
  bit               m_in_ready;
  bit               m_accepted;

  function automatic bit model_out_valid();
    return (q.size() > 0) && q[0].at_out;
  endfunction

  task automatic model_reset();
    q.delete();
    m_o1 = '0;
    m_o2 = '0;
    m_sw = 1'b0;
    m_cnt16 = 0;
    m_cnt2  = 0;
  endtask

  // Run one clock cycle. Inputs are driven after the falling edge, in_ready is
  // checked before the rising edge, the model updates on the rising edge, and
  // the registered outputs are checked at the next falling edge.
  task automatic step(input bit r, input bit iv, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input bit s, input bit m,
                      input bit ordy, input bit clr);
    bit    out_fire;
    bit    in_fire;
    bit    entering;
    bit    dec;
    beat_t nb;
    beat_t hd;
    rst = r; in_valid = iv; op1 = a; op2 = b; sel = s; mode = m;
    out_ready = ordy; cnt_clr = clr;
    m_in_ready = (q.size() < 2) || ordy;
    #1;
    check("in_ready", 64'(in_ready), 64'(m_in_ready));
    check("in_ready_sat", 64'(in_ready_s), 64'(m_in_ready));
    dec = m ? (b > a) : s;
    @(posedge clk);
    m_accepted = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      out_fire = model_out_valid() && ordy;
      in_fire  = iv && m_in_ready;
      if (out_fire) void'(q.pop_front());
      entering = 1'b0;
      if (q.size() > 0 && !q[0].at_out) begin
        hd = q[0];
        hd.at_out = 1'b1;
        q[0] = hd;
        entering = 1'b1;
        m_sw = hd.sw;
        m_o1 = hd.sw ? hd.b : hd.a;
        m_o2 = hd.sw ? hd.a : hd.b;
      end
      if (clr) begin
        m_cnt16 = 0;
        m_cnt2  = 0;
      end else if (entering && m_sw) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (in_fire) begin
        nb.a = a; nb.b = b; nb.sw = dec; nb.at_out = 1'b0;
        q.push_back(nb);
        m_accepted = 1'b1;
      end
    end
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(model_out_valid()));
    check("out1", 64'(out1), 64'(m_o1));
    check("out2", 64'(out2), 64'(m_o2));
    check("swapped", 64'(swapped), 64'(m_sw));
    check("swap_cnt", 64'(swap_cnt), 64'(m_cnt16));
    check("out_valid_sat", 64'(out_valid_s), 64'(model_out_valid()));
    check("out1_sat", 64'(out1_s), 64'(m_o1));
    check("swap_cnt_sat", 64'(swap_cnt_s), 64'(m_cnt2));
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    logic [63:0] v;
    v = {32'($urandom), 32'($urandom)};
    case ($urandom_range(0, 3))
      0: v = 64'($urandom_range(0, 15));
      1: v = v >> $urandom_range(0, 47);
      default: ;
    endcase
    return WIDTH'(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int   beat;
    bit   saw_drop;

    rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; sel = 1'b0; mode = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out1", 64'(out1), 64'(0));
    check("rst_swap_cnt", 64'(swap_cnt), 64'(0));
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // 1: manual swap
    step(1'b0, 1'b1, 48'h5, 48'h9, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_not_yet", 64'(out_valid), 64'(0));
    idle(1'b1);
    check("t1_out1", 64'(out1), 64'h9);
    check("t1_out2", 64'(out2), 64'h5);
    check("t1_swapped", 64'(swapped), 64'(1));
    check("t1_cnt", 64'(swap_cnt), 64'(1));

    // 2: auto compare (unsigned) and the tie case
    step(1'b0, 1'b1, 48'h800000000000, 48'h7FFFFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 48'h123, 48'h123, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t2_out1", 64'(out1), 64'h800000000000);
    check("t2_swapped", 64'(swapped), 64'(0));
    idle(1'b1);
    check("t2_tie_swapped", 64'(swapped), 64'(0));
    check("t2_tie_out1", 64'(out1), 64'h123);
    idle(1'b1);

    // 3: backpressure, with out_ready low for the first 3 cycles
    beat = 0;
    saw_drop = 1'b0;
    for (int cyc = 0; cyc < 20 && beat < 4; cyc++) begin
      step(1'b0, 1'b1, WIDTH'(100 + beat), WIDTH'(200 + beat), beat[0], 1'b0,
           cyc >= 3, 1'b0);
      if (!in_ready && out_valid) saw_drop = 1'b1;
      if (m_accepted) beat++;
    end
    check("t3_in_ready_dropped", 64'(saw_drop), 64'(1));
    check("t3_all_accepted", 64'(beat), 64'(4));
    repeat (4) idle(1'b1);

    // 4: saturation of the 2-bit counter, then cnt_clr against an entering swap
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, WIDTH'(i), WIDTH'(i + 50), 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    check("t4_sat", 64'(swap_cnt_s), 64'(3));
    check("t4_wide", 64'(swap_cnt), 64'(5));
    step(1'b0, 1'b1, 48'h1, 48'h2, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t4_clr_sat", 64'(swap_cnt_s), 64'(0));
    check("t4_clr_wide", 64'(swap_cnt), 64'(0));
    check("t4_swap_entered", 64'(swapped), 64'(1));

    // 5: reset with two beats in flight
    step(1'b0, 1'b1, 48'hAAA, 48'hBBB, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 48'hCCC, 48'hDDD, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_out_valid", 64'(out_valid), 64'(0));
    check("t5_out1", 64'(out1), 64'(0));
    check("t5_cnt", 64'(swap_cnt), 64'(0));
    repeat (3) idle(1'b1);
    check("t5_no_stale", 64'(out_valid), 64'(0));

    // 6: random stream with random backpressure, clears and resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      a = rand_op();
      b = ($urandom_range(0, 7) == 0) ? a : rand_op();
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, a, b,
           1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 63) == 0);
    end
    repeat (4) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
